// File: rtl/debounced_updown_counter.sv
// Two-button debounced up/down counter with optional wrap or saturation at the limits.
// Define AUTO_REPEAT_EN to fire extra pulses every REPEAT_CYCLES clocks while a button is held.
module debounced_updown_counter #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int SATURATE        = 0,
  parameter int REPEAT_CYCLES   = 3000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up_n,
  input  logic             btn_dn_n,
  output logic [WIDTH-1:0] count,
  output logic             up_pulse,
  output logic             dn_pulse,
  output logic             wrap
);

  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0]    DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] COUNT_MAX = '1;

  logic [1:0] raw_n;
  logic [1:0] pulse;

  assign raw_n = {btn_dn_n, btn_up_n};

  // Channel 0 = up, channel 1 = down; all per-channel state is active-low (1 = released).
  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic          sync1_q, sync2_q;
    logic          db_q, db_prev_q;
    logic [DW-1:0] db_cnt_q;
    logic          pulse_q;
    logic          press_evt;
    logic          rep_fire;

    assign press_evt = !db_q && db_prev_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1_q   <= 1'b1;
        sync2_q   <= 1'b1;
        db_q      <= 1'b1;
        db_prev_q <= 1'b1;
        db_cnt_q  <= '0;
        pulse_q   <= 1'b0;
      end else begin
        sync1_q   <= raw_n[c];
        sync2_q   <= sync1_q;
        db_prev_q <= db_q;
        pulse_q   <= press_evt || rep_fire;
        if (sync2_q == db_q) begin
          db_cnt_q <= '0;
        end else if (db_cnt_q == DB_LAST) begin
          db_q     <= ~db_q;
          db_cnt_q <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + 1'b1;
        end
      end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rep_q;

    // Runs only once the press edge has been consumed, so repeats land REPEAT_CYCLES after it.
    assign rep_fire = !db_q && !db_prev_q && (rep_q == REP_LAST);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rep_q <= '0;
      end else if (db_q || db_prev_q || rep_fire) begin
        rep_q <= '0;
      end else begin
        rep_q <= rep_q + 1'b1;
      end
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign pulse[c] = pulse_q;
  end

`ifndef AUTO_REPEAT_EN
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_CYCLES != 0);
`endif

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (pulse[0] && !pulse[1]) begin
      if (count_q != COUNT_MAX) begin
        count_d = count_q + 1'b1;
      end else if (SATURATE == 0) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end
    end else if (pulse[1] && !pulse[0]) begin
      if (count_q != '0) begin
        count_d = count_q - 1'b1;
      end else if (SATURATE == 0) begin
        count_d = COUNT_MAX;
        wrap_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count    = count_q;
  assign up_pulse = pulse[0];
  assign dn_pulse = pulse[1];
  assign wrap     = wrap_q;

endmodule
